// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the 4x4 keypad encoder:
//   - state_t         : scan/debounce FSM states
//   - DEF_SCAN_DIV    : default clocks per column dwell
//   - DEF_DEBOUNCE_CNT: default stable-sample count for press/release
//   - KEY_MAP         : hex code table indexed KEY_MAP[row][col]
//   - first_low_row() : lowest-index low bit of an active-low row pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam int DEF_SCAN_DIV     = 1000;
  localparam int DEF_DEBOUNCE_CNT = 50000;

  // Packed as {row3, row2, row1, row0}, each row as {c3, c2, c1, c0},
  // so KEY_MAP[r][c] is the code for row r / column c.
  //   r0 = 1 2 3 A
  //   r1 = 4 5 6 B
  //   r2 = 7 8 9 C
  //   r3 = E 0 F D
  localparam logic [3:0][3:0][3:0] KEY_MAP = {
    {4'hD, 4'hF, 4'h0, 4'hE},
    {4'hC, 4'h9, 4'h8, 4'h7},
    {4'hB, 4'h6, 4'h5, 4'h4},
    {4'hA, 4'h3, 4'h2, 4'h1}
  };

  // Rows are active-low; when several are low the lowest index wins.
  function automatic logic [1:0] first_low_row(input logic [3:0] pat);
    logic [1:0] sel;
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!pat[i]) sel = 2'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync
//   Two-flop synchronizer for the asynchronous keypad row lines.
//   Both stages reset to all ones (idle, no key pressed).
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset
//     i_d  - asynchronous input bus
//     o_q  - synchronized output bus
module keypad_row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces
//   press and release, and reports accepted keys as hex codes.
//   Ports:
//     clk       - clock
//     rst       - synchronous active-high reset
//     row       - keypad rows, active-low, asynchronous to clk
//     col       - column drive, active-low, exactly one bit low
//     key_code  - code of the last accepted key, held until the next one
//     key_valid - one-cycle pulse when a new key is accepted
//     key_held  - high while the accepted key remains pressed
//   Output protocol: key_valid is a single-cycle strobe with no back-pressure;
//   key_code is already updated in the cycle key_valid is high and stays
//   stable afterwards. key_held rises together with key_valid.
//   The FSM state is held in r_state (state_t) for observation by checkers.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  // Dwell counts 0..SCAN_DIV-1; the stable counter must be able to hold
  // DEBOUNCE_CNT itself, hence the +1.
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_CNT);

  logic [3:0]    w_srow;

  state_t        r_state,    w_state_nx;
  logic [DW-1:0] r_dwell,    w_dwell_nx;
  logic [CW-1:0] r_cnt,      w_cnt_nx;
  logic [1:0]    r_col_idx,  w_col_idx_nx;
  logic [3:0]    r_pattern,  w_pattern_nx;
  logic [3:0]    r_key_code, w_key_code_nx;
  logic          r_key_valid, w_key_valid_nx;
  logic          r_key_held,  w_key_held_nx;

  keypad_row_sync #(
    .WIDTH(4)
  ) u_row_sync (
    .clk(clk),
    .rst(rst),
    .i_d(row),
    .o_q(w_srow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SCAN;
      r_dwell     <= '0;
      r_cnt       <= '0;
      r_col_idx   <= 2'd0;
      r_pattern   <= 4'hF;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_dwell     <= w_dwell_nx;
      r_cnt       <= w_cnt_nx;
      r_col_idx   <= w_col_idx_nx;
      r_pattern   <= w_pattern_nx;
      r_key_code  <= w_key_code_nx;
      r_key_valid <= w_key_valid_nx;
      r_key_held  <= w_key_held_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_dwell_nx     = r_dwell;
    w_cnt_nx       = r_cnt;
    w_col_idx_nx   = r_col_idx;
    w_pattern_nx   = r_pattern;
    w_key_code_nx  = r_key_code;
    w_key_valid_nx = 1'b0;
    w_key_held_nx  = r_key_held;

    case (r_state)
      ST_SCAN: begin
        if (r_dwell == DWELL_LAST) begin
          w_dwell_nx = '0;
          if (w_srow == 4'hF) begin
            w_col_idx_nx = r_col_idx + 2'd1;
          end else begin
            // Column stays frozen on the active one while debouncing.
            w_pattern_nx = w_srow;
            w_cnt_nx     = '0;
            w_state_nx   = ST_DEBOUNCE;
          end
        end else begin
          w_dwell_nx = r_dwell + DW'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (r_cnt == CNT_DONE) begin
          w_key_valid_nx = 1'b1;
          w_key_code_nx  = KEY_MAP[first_low_row(r_pattern)][r_col_idx];
          w_key_held_nx  = 1'b1;
          w_cnt_nx       = '0;
          w_state_nx     = ST_PRESSED;
        end else if (w_srow == r_pattern) begin
          w_cnt_nx = r_cnt + CW'(1);
        end else begin
          // Bounce or release: rescan the same column from a fresh dwell.
          w_cnt_nx   = '0;
          w_dwell_nx = '0;
          w_state_nx = ST_SCAN;
        end
      end

      ST_PRESSED: begin
        if (w_srow == 4'hF) begin
          w_cnt_nx   = '0;
          w_state_nx = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (r_cnt == CNT_DONE) begin
          w_key_held_nx = 1'b0;
          w_col_idx_nx  = r_col_idx + 2'd1;
          w_dwell_nx    = '0;
          w_cnt_nx      = '0;
          w_state_nx    = ST_SCAN;
        end else if (w_srow == 4'hF) begin
          w_cnt_nx = r_cnt + CW'(1);
        end else begin
          // Release glitch: the same key is still down, no new strobe.
          w_cnt_nx   = '0;
          w_state_nx = ST_PRESSED;
        end
      end

      default: begin
        w_state_nx = ST_SCAN;
      end
    endcase
  end

  assign col       = ~(4'b0001 << r_col_idx);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clocks each column is driven before advancing; legal range 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 50000: consecutive stable synced samples required for press or release; legal range 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port row, input, 4 bits: keypad rows, active-low, asynchronous to clk.
REQ-006 SHALL have port col, output, 4 bits: keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port key_code, output, 4 bits: hex code of the last accepted key, held until the next accepted key.
REQ-008 SHALL have port key_valid, output, 1 bit: single-cycle pulse when a new key is accepted.
REQ-009 SHALL have port key_held, output, 1 bit: high while the accepted key remains pressed.

Function
REQ-010 SHALL pass row through a 2-flop synchronizer; all decisions SHALL use only the synced row (srow).
REQ-011 SHALL implement states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-012 In SCAN, a dwell counter SHALL count 0..SCAN_DIV-1 per column; at SCAN_DIV-1 with srow==4'hF, col SHALL advance to the next column, with 3 wrapping to 0.
REQ-013 In SCAN, at dwell count SCAN_DIV-1 with srow!=4'hF, SHALL latch column index and srow pattern, freeze col, and enter DEBOUNCE with stable counter cleared.
REQ-014 In DEBOUNCE, the stable counter SHALL increment each cycle srow equals the latched pattern.
REQ-015 In DEBOUNCE, any mismatch (including all-high) SHALL return to SCAN at the same column with dwell reset to 0.
REQ-016 When the stable counter reaches DEBOUNCE_CNT, the next cycle SHALL set key_valid=1 for exactly one cycle, update key_code, set key_held=1, and enter PRESSED.
REQ-017 If several rows are low in the latched pattern, the lowest-index low row SHALL select the key.
REQ-018 Key map, rows r0..r3 by columns c0..c3: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D.
REQ-019 In PRESSED, col SHALL stay frozen and key_held SHALL stay 1; srow==4'hF SHALL enter RELEASE with the counter cleared.
REQ-020 In RELEASE, the counter SHALL increment while srow==4'hF; any low row SHALL return to PRESSED with no new key_valid.
REQ-021 When the RELEASE counter reaches DEBOUNCE_CNT, SHALL clear key_held, advance col to the next column, and enter SCAN with dwell 0.
REQ-022 key_valid SHALL never assert outside the DEBOUNCE-to-PRESSED transition; holding a key SHALL produce no auto-repeat.
REQ-023 A second key pressed while in PRESSED SHALL be ignored until full release.

Reset
REQ-024 While rst is high at a clk edge, SHALL set state=SCAN, col=4'b1110, key_code=4'h0, key_valid=0, key_held=0, all counters 0, and synchronizer flops 4'hF.
REQ-025 rst asserted in any state, including mid-debounce or mid-press, SHALL take effect the same edge with no key_valid emitted.

Structure
REQ-026 SHALL use a shared package keypad_pkg holding the state enum, the 4x4 key-map constant table, and default SCAN_DIV/DEBOUNCE_CNT values.
REQ-027 The synchronizer SHALL be a separate sub-module named keypad_row_sync (parameterized width, reset value all ones).
REQ-028 Counter widths SHALL be derived via clog2 of the parameters; no wrap-around SHALL be reachable.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-029 Idle: rows 4'hF for 64 cycles -> col cycles 1110,1101,1011,0111 every 4 clocks, wraps, no key_valid.
REQ-030 Press r1/c2 held for 40 cycles, then released -> exactly one key_valid, key_code=4'h6, key_held high until 8 stable-release cycles, then col advances to 0111.
REQ-031 Bounce: r0/c0 low for 3 cycles, high 1, low again steady -> return to SCAN on the glitch, then a single key_valid with key_code=4'h1.
REQ-032 Multiple rows r2 and r3 low on c1 -> key_code=4'h8.
REQ-033 Release glitch: in PRESSED, rows high for 5 cycles then low -> stays PRESSED, no second key_valid, key_held stays 1.
REQ-034 rst pulsed during DEBOUNCE of r3/c3 -> outputs match reset values next cycle, no key_valid, scan restarts at 1110.
